// File: rtl/decoder_scan_n.sv
// ============================================================================
// Module   : decoder_scan_n
// Brief    : Registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
//            Optional macro DECODER_ACTIVE_LOW_EN inverts Out (one-cold).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan_n #(
    parameter int N_IN  = 3,
    parameter int OUT_W = (1 << N_IN),
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E,
    input  logic             mode,
    input  logic [N_IN-1:0]  In,
    output logic [OUT_W-1:0] Out,
    output logic [N_IN-1:0]  idx,
    output logic             wrap
);

    localparam int CNT_W = $clog2(DWELL + 1);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] c_OUT_IDLE = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0] c_OUT_IDLE = {OUT_W{1'b0}};
`endif

    localparam logic [OUT_W-1:0] c_ONE      = OUT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [N_IN-1:0]   r_idx;
    logic [N_IN-1:0]   w_idx_nxt;
    logic [OUT_W-1:0]  r_out;
    logic [OUT_W-1:0]  w_out_nxt;
    logic              r_wrap;
    logic              w_wrap_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= c_OUT_IDLE;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_out   <= w_out_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Out is always rebuilt from the next idx, so it can never be multi-hot.
    // XOR with the idle pattern gives the optional one-cold polarity for free.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = r_idx;
        w_wrap_nxt  = 1'b0;
        w_out_nxt   = c_OUT_IDLE;

        if (!E) begin
            w_state_nxt = S_IDLE;
        end else if (!mode) begin
            w_state_nxt = S_DIRECT;
            w_idx_nxt   = In;
            w_out_nxt   = (c_ONE << In) ^ c_OUT_IDLE;
        end else begin
            w_state_nxt = S_SCAN;
            if (r_state != S_SCAN) begin
                w_idx_nxt = In;
            end else if (r_cnt == c_CNT_LAST) begin
                w_idx_nxt  = r_idx + N_IN'(1);
                w_wrap_nxt = &r_idx;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            w_out_nxt = (c_ONE << w_idx_nxt) ^ c_OUT_IDLE;
        end
    end

    assign Out  = r_out;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan_n.sv
// ============================================================================
// Module   : tb_decoder_scan_n
// Brief    : Directed self-checking bench for decoder_scan_n (DWELL=4 and DWELL=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_scan_n;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] c_POL = 8'hFF;
`else
    localparam logic [7:0] c_POL = 8'h00;
`endif

    logic       clk;
    logic       rst_n;
    logic       E, mode;
    logic [2:0] In;
    logic [7:0] Out;
    logic [2:0] idx;
    logic       wrap;
    logic       E_b, mode_b;
    logic [2:0] In_b;
    logic [7:0] Out_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    int checks   = 0;
    int failures = 0;

    decoder_scan_n #(.N_IN(3), .DWELL(4)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (E),
        .mode (mode),
        .In   (In),
        .Out  (Out),
        .idx  (idx),
        .wrap (wrap)
    );

    decoder_scan_n #(.N_IN(3), .DWELL(1)) u_dut_d1 (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (E_b),
        .mode (mode_b),
        .In   (In_b),
        .Out  (Out_b),
        .idx  (idx_b),
        .wrap (wrap_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hot(input int k);
        logic [7:0] v;
        v = 8'(1 << k) ^ c_POL;
        return {24'd0, v};
    endfunction

    initial begin
        rst_n = 1'b1; E = 1'b0; mode = 1'b0; In = 3'd0;
        E_b = 1'b0; mode_b = 1'b0; In_b = 3'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", {24'd0, Out}, {24'd0, c_POL});
        chk("rst_idx", {29'd0, idx}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_out_d1", {24'd0, Out_b}, {24'd0, c_POL});
        tick();
        tick();

        // DIRECT: each code appears one edge after it is presented
        rst_n = 1'b1; E = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            In = 3'(i);
            tick();
            chk("direct_out", {24'd0, Out}, hot(i));
            chk("direct_idx", {29'd0, idx}, 32'(i));
            chk("direct_wrap", {31'd0, wrap}, 32'd0);
        end

        // SCAN entry from 6: 0x40 x4, 0x80 x4, then 0x01 with wrap
        mode = 1'b1; In = 3'd6;
        tick();
        chk("entry_out", {24'd0, Out}, hot(6));
        chk("entry_idx", {29'd0, idx}, 32'd6);
        In = 3'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold6_out", {24'd0, Out}, hot(6));
        end
        tick();
        chk("adv7_out", {24'd0, Out}, hot(7));
        chk("adv7_wrap", {31'd0, wrap}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold7_out", {24'd0, Out}, hot(7));
        end
        tick();
        chk("wrap_out", {24'd0, Out}, hot(0));
        chk("wrap_pulse", {31'd0, wrap}, 32'd1);
        chk("wrap_idx", {29'd0, idx}, 32'd0);

        // Two full sweeps: wrap exactly every 32 cycles
        for (int t = 1; t <= 64; t++) begin
            tick();
            chk("sweep_out", {24'd0, Out}, hot((t / 4) % 8));
            chk("sweep_wrap", {31'd0, wrap}, 32'((t % 32) == 0));
        end

        // E low for two cycles mid-scan at idx=5, then restart from In
        for (int k = 0; k < 21; k++) tick();
        chk("pre_idle_idx", {29'd0, idx}, 32'd5);
        E = 1'b0; In = 3'd2;
        tick();
        chk("idle1_out", {24'd0, Out}, {24'd0, c_POL});
        chk("idle1_idx", {29'd0, idx}, 32'd5);
        tick();
        chk("idle2_out", {24'd0, Out}, {24'd0, c_POL});
        E = 1'b1;
        tick();
        chk("resume_out", {24'd0, Out}, hot(2));
        chk("resume_idx", {29'd0, idx}, 32'd2);
        for (int k = 0; k < 3; k++) tick();
        chk("resume_hold", {24'd0, Out}, hot(2));
        tick();
        chk("resume_adv", {24'd0, Out}, hot(3));

        // SCAN -> DIRECT -> SCAN reloads from In with a fresh dwell
        tick();
        mode = 1'b0; In = 3'd7;
        tick();
        chk("s2d_out", {24'd0, Out}, hot(7));
        mode = 1'b1; In = 3'd3;
        tick();
        chk("d2s_idx", {29'd0, idx}, 32'd3);
        for (int k = 0; k < 3; k++) tick();
        chk("d2s_hold", {24'd0, Out}, hot(3));
        tick();
        chk("d2s_adv", {24'd0, Out}, hot(4));

        // E=0 wins over mode=1
        E = 1'b0;
        tick();
        chk("prio_out", {24'd0, Out}, {24'd0, c_POL});

        // Asynchronous reset during the wrap cycle
        E = 1'b1; In = 3'd7;
        tick();
        for (int k = 0; k < 3; k++) tick();
        tick();
        chk("pre_rst_wrap", {31'd0, wrap}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", {24'd0, Out}, {24'd0, c_POL});
        chk("arst_wrap", {31'd0, wrap}, 32'd0);
        In = 3'd5;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerun_out", {24'd0, Out}, hot(5));
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_idx", {29'd0, idx}, 32'd0);
        chk("arst_out2", {24'd0, Out}, {24'd0, c_POL});
        E = 1'b0;
        tick();
        rst_n = 1'b1;

        // DWELL=1 instance: advances every cycle, wrap every 8 cycles
        E_b = 1'b1; mode_b = 1'b1; In_b = 3'd0;
        tick();
        chk("d1_entry_out", {24'd0, Out_b}, hot(0));
        chk("d1_entry_wrap", {31'd0, wrap_b}, 32'd0);
        for (int t = 1; t <= 16; t++) begin
            tick();
            chk("d1_out", {24'd0, Out_b}, hot(t % 8));
            chk("d1_idx", {29'd0, idx_b}, 32'(t % 8));
            chk("d1_wrap", {31'd0, wrap_b}, 32'((t % 8) == 0));
        end
        E_b = 1'b0;
        tick();
        chk("d1_idle_out", {24'd0, Out_b}, {24'd0, c_POL});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
